mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Clock and reset: clk is the clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  E-stage pulse launching the operation selected by md_op.
REQ-005 md_op  input  3  operation code:
- 0 none
- 1 mult
- 2 multu
- 3 div
- 4 divu
- 5 mthi
- 6 mtlo
- 7 reserved, treated as none.
REQ-006 rs_val  input  32  forwarded E-stage rs operand (dividend, multiplicand, mthi/mtlo source).
REQ-007 rt_val  input  32  forwarded E-stage rt operand (divisor, multiplier).
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 md_hazard  output  1  combinational OR of start (md_op 1-4) and busy; drives the D-stage stall for mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 Latency: mult/multu = 5 cycles; div/divu = 10 cycles.
REQ-013 Launch capture: on a rising edge with start=1, md_op in 1-4 and busy=0, the unit:
- latches rs_val, rt_val and md_op;
- loads the cycle counter with the op's latency;
- sets busy=1 from the next cycle.
REQ-014 busy = (counter != 0); the counter decrements by 1 on every edge while nonzero.
REQ-015 Completion: on the edge where the counter goes 1->0, hi/lo take the result and busy falls; new hi/lo are visible in the same cycle busy reads 0.
REQ-016 Busy window: busy is high for exactly N cycles after the launch edge (N = latency), with no gap and no overlap.
REQ-017 mult: {hi,lo} = signed 64-bit product of rs and rt.
REQ-018 multu: {hi,lo} = unsigned 64-bit product of rs and rt.
REQ-019 div: lo = signed quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-020 div overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-021 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-022 Divide by zero (div/divu with rt=0): runs the full 10 cycles with busy asserted, then leaves hi/lo unchanged.
REQ-023 mthi/mtlo: with start=1 and busy=0, write rs_val into hi (op 5) or lo (op 6) at that edge; busy stays 0; zero latency.
REQ-024 Start while busy: ignored for all ops; no operand capture, no hi/lo write, counter unaffected.
REQ-025 Operand stability: captured operands, not live rs_val/rt_val, are used for the whole operation; input changes mid-operation have no effect.
REQ-026 Same-edge completion and launch: a start with busy=1 on the completion edge is ignored, because busy is still 1 at that edge.
REQ-027 Idle: with start=0 or md_op in {0,7}, hi, lo and counter hold.
REQ-028 Read path: hi/lo are plain register outputs; mfhi/mflo read them combinationally in E.

Reset
REQ-029 At an edge with reset=1:
- hi=0, lo=0, counter=0, busy=0;
- captured operands and op are cleared;
- start is ignored.
REQ-030 Reset during an operation aborts it: no hi/lo update occurs afterwards, and busy is 0 in the cycle following the reset edge.
REQ-031 Power-up: registers initialise to the same values as reset.

Verification
REQ-032 Scenario mult: rs=0xFFFFFFFE (-2), rt=3, start, op=1 ->
- busy high for 5 cycles;
- then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 Scenario multu: rs=0xFFFFFFFF, rt=0xFFFFFFFF, op=2 ->
- after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 Scenario div: rs=0xFFFFFFF9 (-7), rt=2, op=3 ->
- busy for 10 cycles;
- then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-035 Scenario divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo, then divu rs=5, rt=0 ->
- busy for 10 cycles;
- then hi=0x11, lo=0x22 unchanged.
REQ-036 Scenario busy and stall: launch mult with rs=3, rt=4; in cycle 2 of busy, pulse start op=6 rs=0x55 ->
- the mtlo is ignored;
- final lo=12, hi=0;
- md_hazard high from the launch cycle through the last busy cycle.
REQ-037 Scenario reset mid-op: launch div rs=100, rt=7; assert reset in busy cycle 4 ->
- busy=0, hi=0, lo=0 after the reset edge;
- no later update of hi/lo.

Source files
------------

// File: rtl/mdu_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit_if
// Purpose  : E-stage request / HI-LO result bundle between the pipeline and
//            the multiply/divide unit.
// Signals  : start     - E-stage launch pulse
//            md_op     - operation code (0 none, 1 mult, 2 multu, 3 div,
//                        4 divu, 5 mthi, 6 mtlo, 7 reserved/none)
//            rs_val    - forwarded rs operand
//            rt_val    - forwarded rt operand
//            busy      - operation in flight
//            md_hazard - D-stage stall request
//            hi, lo    - architectural HI/LO registers
// Modports : master (pipeline side), slave (mdu_unit side)
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_hazard;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, md_hazard, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, md_hazard, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
//            mult/multu take 5 cycles, div/divu take 10; mthi/mtlo write in
//            zero cycles. Results land in HI/LO on the edge busy falls.
// Ports    : clk   - rising-edge clock
//            reset - synchronous active-high reset
//            bus   - mdu_unit_if.slave (start, md_op, rs_val, rt_val in;
//                    busy, md_hazard, hi, lo out)
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit (
  input  wire logic   clk,
  input  wire logic   reset,
  mdu_unit_if.slave   bus
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [3:0] c_lat_mult = 4'd5;
  localparam logic [3:0] c_lat_div  = 4'd10;

  logic [3:0]  r_count;
  logic [2:0]  r_op;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_busy;
  logic        w_launch_op;
  logic        w_is_sdiv;
  logic        w_is_div;
  logic        w_div_zero;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [31:0] w_num;
  logic [31:0] w_den_raw;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_busy      = (r_count != 4'd0);
  assign w_launch_op = (bus.md_op >= c_op_mult) && (bus.md_op <= c_op_divu);

  assign bus.busy      = w_busy;
  assign bus.md_hazard = (bus.start && w_launch_op) || w_busy;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

  // Products are formed from the captured operands only.
  assign w_sprod = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
  assign w_uprod = {32'd0, r_rs} * {32'd0, r_rt};

  // Signed division is done on magnitudes through a single unsigned divider,
  // then the signs are reapplied. This also gives 0x80000000 / -1 the
  // wrapped result (quotient 0x80000000, remainder 0) without overflow.
  assign w_is_sdiv  = (r_op == c_op_div);
  assign w_is_div   = (r_op == c_op_div) || (r_op == c_op_divu);
  assign w_rs_mag   = r_rs[31] ? (32'd0 - r_rs) : r_rs;
  assign w_rt_mag   = r_rt[31] ? (32'd0 - r_rt) : r_rt;
  assign w_num      = w_is_sdiv ? w_rs_mag : r_rs;
  assign w_den_raw  = w_is_sdiv ? w_rt_mag : r_rt;
  assign w_div_zero = w_is_div && (r_rt == 32'd0);
  // Keep the divider away from a zero divisor; the result is discarded then.
  assign w_den      = (w_den_raw == 32'd0) ? 32'd1 : w_den_raw;
  assign w_uq       = w_num / w_den;
  assign w_ur       = w_num % w_den;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      c_op_mult: begin
        w_res_hi = w_sprod[63:32];
        w_res_lo = w_sprod[31:0];
      end
      c_op_multu: begin
        w_res_hi = w_uprod[63:32];
        w_res_lo = w_uprod[31:0];
      end
      c_op_div: begin
        w_res_lo = (r_rs[31] ^ r_rt[31]) ? (32'd0 - w_uq) : w_uq;
        w_res_hi = r_rs[31] ? (32'd0 - w_ur) : w_ur;
      end
      c_op_divu: begin
        w_res_lo = w_uq;
        w_res_hi = w_ur;
      end
      default: begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
      r_op    <= 3'd0;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else if (w_busy) begin
      // Any start seen while busy (including on the completion edge) is dropped.
      r_count <= r_count - 4'd1;
      if ((r_count == 4'd1) && !w_div_zero) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else if (bus.start) begin
      case (bus.md_op)
        c_op_mult, c_op_multu: begin
          r_op    <= bus.md_op;
          r_rs    <= bus.rs_val;
          r_rt    <= bus.rt_val;
          r_count <= c_lat_mult;
        end
        c_op_div, c_op_divu: begin
          r_op    <= bus.md_op;
          r_rs    <= bus.rs_val;
          r_rt    <= bus.rt_val;
          r_count <= c_lat_div;
        end
        c_op_mthi: r_hi <= bus.rs_val;
        c_op_mtlo: r_lo <= bus.rs_val;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Directed self-checking bench for mdu_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_unit_if bus ();

  mdu_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
  endtask

  // Single-cycle start pulse with the given op and operands.
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    tick();
    idle_inputs();
  endtask

  // Launch a mult/div op, then count busy cycles while scrambling the live
  // operands to show the captured ones are used.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int lat);
    int n;
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    check({tag, "_hazard_launch"}, {31'd0, bus.md_hazard}, 32'd1);
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      tick();
    end
    check({tag, "_busy_cycles"}, n, lat);
  endtask

  initial begin
    int n;
    logic haz_ok;
    checks   = 0;
    failures = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hazard", {31'd0, bus.md_hazard}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    // mult -2 * 3
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // multu max * max
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    // div -7 / 2
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    // div 7 / -2 : quotient -3, remainder +1 (sign of dividend)
    run_op("div_negdvs", 3'd3, 32'd7, 32'hFFFF_FFFE, 10);
    check("div_negdvs_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_negdvs_hi", bus.hi, 32'd1);

    // div overflow
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);

    // divu 100 / 7
    run_op("divu", 3'd4, 32'd100, 32'd7, 10);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    // mthi / mtlo then divide by zero
    bus.start = 1'b1; bus.md_op = 3'd5; bus.rs_val = 32'h11;
    #1;
    check("mthi_hazard", {31'd0, bus.md_hazard}, 32'd0);
    tick();
    idle_inputs();
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    check("mthi_hi", bus.hi, 32'h11);
    pulse(3'd6, 32'h22, 32'd0);
    check("mtlo_lo", bus.lo, 32'h22);
    run_op("divz", 3'd4, 32'd5, 32'd0, 10);
    check("divz_hi", bus.hi, 32'h11);
    check("divz_lo", bus.lo, 32'h22);

    // Busy and stall: mtlo in busy cycle 2 must be ignored
    bus.start = 1'b1; bus.md_op = 3'd1; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    #1;
    haz_ok = bus.md_hazard;
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      haz_ok = haz_ok & bus.md_hazard;
      if (n == 2) begin
        bus.start = 1'b1; bus.md_op = 3'd6; bus.rs_val = 32'h55;
      end
      tick();
      idle_inputs();
    end
    check("stall_busy_cycles", n, 5);
    check("stall_hazard_window", {31'd0, haz_ok}, 32'd1);
    check("stall_hazard_after", {31'd0, bus.md_hazard}, 32'd0);
    check("stall_lo", bus.lo, 32'd12);
    check("stall_hi", bus.hi, 32'd0);

    // Same-edge completion and launch: start in the last busy cycle is dropped
    bus.start = 1'b1; bus.md_op = 3'd1; bus.rs_val = 32'd2; bus.rt_val = 32'd5;
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == 5) begin
        bus.start = 1'b1; bus.md_op = 3'd1; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
      end
      tick();
      idle_inputs();
    end
    check("sameedge_busy_cycles", n, 5);
    check("sameedge_lo", bus.lo, 32'd10);
    tick();
    check("sameedge_no_relaunch", {31'd0, bus.busy}, 32'd0);

    // Reserved op and op 0 hold everything
    pulse(3'd7, 32'hDEAD_BEEF, 32'd1);
    pulse(3'd0, 32'hDEAD_BEEF, 32'd1);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_lo", bus.lo, 32'd10);

    // Reset mid-op in busy cycle 4
    bus.start = 1'b1; bus.md_op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    tick();
    idle_inputs();
    for (int i = 1; i < 4; i++) tick();
    check("rstmid_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    check("rstmid_hi", bus.hi, 32'd0);
    check("rstmid_lo", bus.lo, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("rstmid_hi_later", bus.hi, 32'd0);
    check("rstmid_lo_later", bus.lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
